// File: rtl/mul_pkg.sv
// mul_pkg: shared product width, count-field width and accumulator FSM states.
package mul_pkg;
   localparam int PROD_W_DEF = 8;
   localparam int CNT_W = 8;
   typedef enum logic {ACCUM, OUTPUT} state_t;
endpackage

// File: rtl/mul_accum_reg.sv
// mul_accum_reg: accumulator adder with carry detect; MUL_ACCUM_SATURATE_EN clamps on carry instead of wrapping.
module mul_accum_reg #(
   parameter int PROD_W = 8,
   parameter int ACC_W = 16
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);
   logic [ACC_W:0] full;
   assign full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
   assign carry = full[ACC_W];
`ifdef MUL_ACCUM_SATURATE_EN
   // once clamped, any further add carries again, so the clamp holds for the frame
   assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
   assign sum = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/mul_product_accum.sv
// mul_product_accum: sums COUNT products (or up to prod_last) and presents the frame result on a valid/ready port.
// Build option MUL_ACCUM_SATURATE_EN selects saturating rather than wrapping accumulation.
module mul_product_accum
   import mul_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W = 16,
   parameter int COUNT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod_data,
   input  logic              prod_last,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc_data,
   output logic [CNT_W-1:0]  acc_count,
   output logic              overflow
);
   state_t state;
   logic [ACC_W-1:0] acc, sum;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic sticky, carry, ovf_nx, done;

   mul_accum_reg #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
      .acc(acc),
      .prod(prod_data),
      .sum(sum),
      .carry(carry)
   );

   assign cnt_nx = cnt + CNT_W'(1);
   assign ovf_nx = sticky | carry;
   assign done = (cnt_nx == CNT_W'(COUNT)) || prod_last;

   // handshake flags are registered so prod_ready never depends on acc_ready combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ACCUM;
         acc        <= '0;
         cnt        <= '0;
         sticky     <= 1'b0;
         prod_ready <= 1'b0;
         acc_valid  <= 1'b0;
         acc_data   <= '0;
         acc_count  <= '0;
         overflow   <= 1'b0;
      end else if (state == ACCUM) begin
         prod_ready <= 1'b1;
         if (prod_valid && prod_ready) begin
            acc    <= sum;
            cnt    <= cnt_nx;
            sticky <= ovf_nx;
            if (done) begin
               acc_data   <= sum;
               acc_count  <= cnt_nx;
               overflow   <= ovf_nx;
               acc_valid  <= 1'b1;
               prod_ready <= 1'b0;
               state      <= OUTPUT;
            end
         end
      end else if (acc_ready) begin
         acc        <= '0;
         cnt        <= '0;
         sticky     <= 1'b0;
         acc_valid  <= 1'b0;
         prod_ready <= 1'b1;
         state      <= ACCUM;
      end
   end
endmodule
